// File: rtl/tape_access_arbiter.sv
// Arbitrates the single data-tape RAM between the CPU and debug ports, sequencing
// READ / WRITE / ADD (read-modify-write) onto a 1-cycle-latency read port and a write port.
module tape_access_arbiter #(
  parameter int unsigned CELL_W     = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cpu_req_i,
  input  logic [1:0]               cpu_op_i,
  input  logic [$clog2(DEPTH)-1:0] cpu_addr_i,
  input  logic [CELL_W-1:0]        cpu_data_i,
  output logic                     cpu_ack_o,
  output logic [CELL_W-1:0]        cpu_rdata_o,
  input  logic                     dbg_req_i,
  input  logic [1:0]               dbg_op_i,
  input  logic [$clog2(DEPTH)-1:0] dbg_addr_i,
  input  logic [CELL_W-1:0]        dbg_data_i,
  output logic                     dbg_ack_o,
  output logic [CELL_W-1:0]        dbg_rdata_o,
  output logic                     mem_ren_o,
  output logic [$clog2(DEPTH)-1:0] mem_raddr_o,
  input  logic [CELL_W-1:0]        mem_rdata_i,
  output logic                     mem_wen_o,
  output logic [$clog2(DEPTH)-1:0] mem_waddr_o,
  output logic [CELL_W-1:0]        mem_wdata_o,
  output logic                     busy_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_MOD  = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;

  logic [2:0]        state_q,     state_d;
  logic              owner_q,     owner_d;
  logic [1:0]        op_q,        op_d;
  logic [AW-1:0]     addr_q,      addr_d;
  logic [CELL_W-1:0] data_q,      data_d;
  logic [CELL_W-1:0] result_q,    result_d;
  logic              rd_wait_q,   rd_wait_d;
  logic [SW-1:0]     starve_q,    starve_d;
  logic [CELL_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [CELL_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic [CELL_W-1:0] sum;
  logic              cpu_grant;

  assign sum = mem_rdata_i + data_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      op_q        <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      result_q    <= '0;
      rd_wait_q   <= 1'b0;
      starve_q    <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      result_q    <= result_d;
      rd_wait_q   <= rd_wait_d;
      starve_q    <= starve_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    op_d        = op_q;
    addr_d      = addr_q;
    data_d      = data_q;
    result_d    = result_q;
    rd_wait_d   = rd_wait_q;
    starve_d    = starve_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    cpu_grant   = cpu_req_i && !(dbg_req_i && (starve_q == STARVE_LIM));
    case (state_q)
      S_IDLE: begin
        rd_wait_d = 1'b0;
        if (cpu_grant) begin
          owner_d = 1'b0;
          op_d    = cpu_op_i;
          addr_d  = cpu_addr_i;
          data_d  = cpu_data_i;
          state_d = (cpu_op_i == OP_WR) ? S_WR : S_RD;
          if (!dbg_req_i)
            starve_d = '0;
          else if (starve_q != STARVE_LIM)
            starve_d = starve_q + 1'b1;
        end else if (dbg_req_i) begin
          owner_d  = 1'b1;
          op_d     = dbg_op_i;
          addr_d   = dbg_addr_i;
          data_d   = dbg_data_i;
          state_d  = (dbg_op_i == OP_WR) ? S_WR : S_RD;
          starve_d = '0;
        end else begin
          starve_d = '0;
        end
      end
      // A plain READ stays in RD one extra cycle (read enable dropped) so the
      // RAM data can be captured before DONE, giving the 3-cycle READ latency.
      S_RD: begin
        if (op_q == OP_ADD) begin
          state_d = S_MOD;
        end else if (!rd_wait_q) begin
          rd_wait_d = 1'b1;
        end else begin
          rd_wait_d = 1'b0;
          result_d  = mem_rdata_i;
          state_d   = S_DONE;
        end
      end
      S_MOD: begin
        result_d = sum;
        state_d  = S_DONE;
      end
      S_WR: begin
        result_d = data_q;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (owner_q) dbg_rdata_d = result_q;
        else         cpu_rdata_d = result_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o      = (state_q != S_IDLE);
  assign mem_ren_o   = (state_q == S_RD) && !rd_wait_q;
  assign mem_raddr_o = mem_ren_o ? addr_q : '0;
  assign mem_wen_o   = (state_q == S_MOD) || (state_q == S_WR);
  assign mem_waddr_o = mem_wen_o ? addr_q : '0;
  assign mem_wdata_o = (state_q == S_MOD) ? sum :
                       (state_q == S_WR)  ? data_q : '0;

  assign cpu_ack_o   = (state_q == S_DONE) && !owner_q;
  assign dbg_ack_o   = (state_q == S_DONE) &&  owner_q;
  assign cpu_rdata_o = cpu_ack_o ? result_q : cpu_rdata_q;
  assign dbg_rdata_o = dbg_ack_o ? result_q : dbg_rdata_q;

endmodule

// File: tb/tb_tape_access_arbiter.sv
// Directed bench for tape_access_arbiter: a RAM model behind the DUT, a shadow tape
// for expected values, and scoreboards for acked results and RAM writes.
module tb_tape_access_arbiter;

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cpu_req = 1'b0, dbg_req = 1'b0;
  logic [1:0] cpu_op = '0, dbg_op = '0;
  logic [2:0] cpu_addr = '0, dbg_addr = '0;
  logic [7:0] cpu_data = '0, dbg_data = '0;
  logic       cpu_ack, dbg_ack, mem_ren, mem_wen, busy;
  logic [7:0] cpu_rdata, dbg_rdata, mem_rdata, mem_wdata;
  logic [2:0] mem_raddr, mem_waddr;

  logic [7:0]  ram [8];
  logic [7:0]  ref_mem [8];
  logic [7:0]  cpu_q [$];
  logic [7:0]  dbg_q [$];
  logic [10:0] wr_q [$];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tape_access_arbiter #(.CELL_W(8), .DEPTH(8), .STARVE_MAX(4)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .cpu_req_i(cpu_req), .cpu_op_i(cpu_op), .cpu_addr_i(cpu_addr), .cpu_data_i(cpu_data),
    .cpu_ack_o(cpu_ack), .cpu_rdata_o(cpu_rdata),
    .dbg_req_i(dbg_req), .dbg_op_i(dbg_op), .dbg_addr_i(dbg_addr), .dbg_data_i(dbg_data),
    .dbg_ack_o(dbg_ack), .dbg_rdata_o(dbg_rdata),
    .mem_ren_o(mem_ren), .mem_raddr_o(mem_raddr), .mem_rdata_i(mem_rdata),
    .mem_wen_o(mem_wen), .mem_waddr_o(mem_waddr), .mem_wdata_o(mem_wdata),
    .busy_o(busy)
  );

  // RAM model: 1-cycle read latency, synchronous write
  initial begin
    mem_rdata = '0;
    for (int i = 0; i < 8; i++) begin
      ram[i]     = 8'(8'h11 * i);
      ref_mem[i] = 8'(8'h11 * i);
    end
  end
  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= ram[mem_raddr];
    if (mem_wen) ram[mem_waddr] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumers, sampled on the falling edge
  always @(negedge clk) begin
    if (mem_ren || mem_wen) check("mem_rw_exclusive", 32'(mem_ren & mem_wen), 32'd0);
    if (cpu_ack) begin
      if (cpu_q.size() == 0) check("cpu_unexpected_ack", 32'd1, 32'd0);
      else check("cpu_rdata", 32'(cpu_rdata), 32'(cpu_q.pop_front()));
    end
    if (dbg_ack) begin
      if (dbg_q.size() == 0) check("dbg_unexpected_ack", 32'd1, 32'd0);
      else check("dbg_rdata", 32'(dbg_rdata), 32'(dbg_q.pop_front()));
    end
    if (cpu_ack && dbg_ack) check("both_ack", 32'd1, 32'd0);
    if (mem_wen) begin
      if (wr_q.size() == 0) check("unexpected_write", 32'd1, 32'd0);
      else check("mem_write", 32'({mem_waddr, mem_wdata}), 32'(wr_q.pop_front()));
    end
  end

  // Expected result for an op, updating the shadow tape in grant order
  function automatic logic [7:0] model_op(input logic [1:0] op, input logic [2:0] a,
                                          input logic [7:0] d);
    logic [7:0] r;
    case (op)
      OP_WR:   begin r = d; ref_mem[a] = r; wr_q.push_back({a, r}); end
      OP_ADD:  begin r = ref_mem[a] + d; ref_mem[a] = r; wr_q.push_back({a, r}); end
      default: r = ref_mem[a];
    endcase
    return r;
  endfunction

  task automatic run_op(input bit is_dbg, input logic [1:0] op, input logic [2:0] a,
                        input logic [7:0] d, input int exp_lat, input string tag);
    int  lat;
    bit  got;
    logic [7:0] r;
    @(negedge clk); #1;
    r = model_op(op, a, d);
    if (is_dbg) begin
      dbg_q.push_back(r);
      dbg_op = op; dbg_addr = a; dbg_data = d; dbg_req = 1'b1;
    end else begin
      cpu_q.push_back(r);
      cpu_op = op; cpu_addr = a; cpu_data = d; cpu_req = 1'b1;
    end
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk); lat++;
      @(negedge clk); #1;
      got = is_dbg ? dbg_ack : cpu_ack;
    end
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    check(tag, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    int cyc, k, nc, nd, cpu_lat, dbg_lat;
    logic [9:0] order;

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_en", 32'({mem_ren, mem_wen}), 32'd0);
    check("rst_acks", 32'({cpu_ack, dbg_ack}), 32'd0);
    check("rst_rdata", 32'({cpu_rdata, dbg_rdata}), 32'd0);
    #1 rst_n = 1'b1;

    run_op(1'b0, OP_WR,  3'd3, 8'h5A, 2, "cpu_write_lat");
    check("tape3_after_write", 32'(ram[3]), 32'h5A);
    run_op(1'b0, OP_ADD, 3'd3, 8'hFF, 3, "cpu_add_wrap_lat");
    check("cpu_rdata_held", 32'(cpu_rdata), 32'h59);
    run_op(1'b0, 2'b11,  3'd3, 8'h00, 3, "cpu_read_op11_lat");

    // Simultaneous READs: CPU first, debug after CPU op plus one IDLE cycle
    @(negedge clk); #1;
    cpu_q.push_back(model_op(OP_RD, 3'd3, 8'h00));
    dbg_q.push_back(model_op(OP_RD, 3'd0, 8'h00));
    cpu_op = OP_RD; cpu_addr = 3'd3; cpu_req = 1'b1;
    dbg_op = OP_RD; dbg_addr = 3'd0; dbg_req = 1'b1;
    cyc = 0; cpu_lat = 0; dbg_lat = 0;
    while (dbg_lat == 0 && cyc < 40) begin
      @(posedge clk); cyc++;
      @(negedge clk); #1;
      if (cpu_ack) begin cpu_lat = cyc; cpu_req = 1'b0; end
      if (dbg_ack) begin dbg_lat = cyc; dbg_req = 1'b0; end
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    check("conc_cpu_lat", 32'(cpu_lat), 32'd3);
    check("conc_dbg_lat", 32'(dbg_lat), 32'd7);

    // Both held: four CPU grants then one debug grant, twice
    @(negedge clk); #1;
    cpu_q.push_back(model_op(OP_RD, 3'd1, 8'h00));
    dbg_q.push_back(model_op(OP_RD, 3'd2, 8'h00));
    cpu_op = OP_RD; cpu_addr = 3'd1; cpu_req = 1'b1;
    dbg_op = OP_RD; dbg_addr = 3'd2; dbg_req = 1'b1;
    cyc = 0; k = 0; nc = 0; nd = 0; order = '0;
    while (k < 10 && cyc < 200) begin
      @(posedge clk); cyc++;
      @(negedge clk); #1;
      if (cpu_ack) begin
        order[k] = 1'b0; k++; nc++;
        if (nc < 8) cpu_q.push_back(model_op(OP_RD, 3'd1, 8'h00));
        else cpu_req = 1'b0;
      end
      if (dbg_ack) begin
        order[k] = 1'b1; k++; nd++;
        if (nd < 2) dbg_q.push_back(model_op(OP_RD, 3'd2, 8'h00));
        else dbg_req = 1'b0;
      end
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    check("starve_grants", 32'(k), 32'd10);
    check("starve_order", 32'(order), 32'h210);

    // Debug ADD wrapping 0xFF -> 0x00; CPU side stays quiet and holds its data
    run_op(1'b1, OP_WR,  3'd7, 8'hFF, 2, "dbg_write_lat");
    run_op(1'b1, OP_ADD, 3'd7, 8'h01, 3, "dbg_add_lat");
    check("dbg_rdata_held", 32'(dbg_rdata), 32'h00);
    check("cpu_rdata_untouched", 32'(cpu_rdata), 32'h11);
    check("tape7_wrapped", 32'(ram[7]), 32'h00);

    // Reset asserted while in MOD: outputs clear at once, write lost, no ack
    @(negedge clk); #1;
    wr_q.push_back({3'd0, 8'(ref_mem[0] + 8'h05)});
    cpu_op = OP_ADD; cpu_addr = 3'd0; cpu_data = 8'h05; cpu_req = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk); #1;
    check("mod_wen", 32'(mem_wen), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_mem", 32'({mem_ren, mem_wen, mem_waddr, mem_wdata, mem_raddr}), 32'd0);
    check("midrst_acks", 32'({cpu_ack, dbg_ack}), 32'd0);
    check("midrst_rdata", 32'({cpu_rdata, dbg_rdata}), 32'd0);
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_idle", 32'(busy), 32'd0);
    check("tape0_write_lost", 32'(ram[0]), 32'(ref_mem[0]));
    run_op(1'b0, OP_RD, 3'd0, 8'h00, 3, "post_rst_read_lat");

    repeat (3) @(negedge clk);
    check("cpu_sb_empty", 32'(cpu_q.size()), 32'd0);
    check("dbg_sb_empty", 32'(dbg_q.size()), 32'd0);
    check("wr_sb_empty",  32'(wr_q.size()),  32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
